// File: rtl/uzorak_deserializer_if.sv
// Stream bundle between the sonar feature source, the deserializer and Neuron_1_FL.
// The deserializer takes the slave side: it sinks features and sources the sample.
interface uzorak_deserializer_if #(
    parameter int N_FEAT = 60,
    parameter int W      = 16
);
    logic [W-1:0]        in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [N_FEAT*W-1:0] uzorak;
    logic                uzorak_valid;
    logic                uzorak_ready;

    modport slave (
        input  in_data, in_valid, in_last, uzorak_ready,
        output in_ready, uzorak, uzorak_valid
    );

    modport master (
        output in_data, in_valid, in_last, uzorak_ready,
        input  in_ready, uzorak, uzorak_valid
    );
endinterface

// File: rtl/uzorak_deserializer.sv
// Packs N_FEAT words of W bits (first word in the MSBs) into one sample vector,
// holds it until acknowledged, and discards frames of the wrong length.
module uzorak_deserializer #(
    parameter int N_FEAT = 60,
    parameter int W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uzorak_deserializer_if.slave bus,
    output logic                 frame_err,
    output logic [7:0]           sample_cnt
);
    localparam int IDX_W = $clog2(N_FEAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             in_ready_reg;
    logic             uzorak_valid_reg;
    logic             frame_err_reg;
    logic [7:0]       sample_cnt_reg;

    logic accept;
    logic wr_en;

    assign accept = bus.in_valid && in_ready_reg;
    assign wr_en  = accept && (state_reg == FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= FILL;
            idx_reg          <= '0;
            in_ready_reg     <= 1'b1;
            uzorak_valid_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
            sample_cnt_reg   <= 8'd0;
        end else begin
            frame_err_reg <= 1'b0;
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        if (idx_reg == LAST_IDX) begin
                            idx_reg <= '0;
                            if (bus.in_last) begin
                                state_reg        <= FULL;
                                in_ready_reg     <= 1'b0;
                                uzorak_valid_reg <= 1'b1;
                            end else begin
                                // Too many words: flag now, swallow the rest of the frame.
                                state_reg     <= DROP;
                                frame_err_reg <= 1'b1;
                            end
                        end else if (bus.in_last) begin
                            idx_reg       <= '0;
                            frame_err_reg <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (bus.uzorak_ready) begin
                        state_reg        <= FILL;
                        in_ready_reg     <= 1'b1;
                        uzorak_valid_reg <= 1'b0;
                        sample_cnt_reg   <= sample_cnt_reg + 8'd1;
                    end
                end
                DROP: begin
                    if (accept && bus.in_last) begin
                        state_reg <= FILL;
                    end
                end
                default: begin
                    state_reg        <= FILL;
                    idx_reg          <= '0;
                    in_ready_reg     <= 1'b1;
                    uzorak_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // One register per feature slot; slot gi sits at the gi-th word from the top.
    generate
        for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_feat
            logic [W-1:0] word_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (wr_en && (idx_reg == IDX_W'(gi))) begin
                    word_reg <= bus.in_data;
                end
            end

            assign bus.uzorak[N_FEAT*W-1-gi*W -: W] = word_reg;
        end
    endgenerate

    assign bus.in_ready     = in_ready_reg;
    assign bus.uzorak_valid = uzorak_valid_reg;
    assign frame_err        = frame_err_reg;
    assign sample_cnt       = sample_cnt_reg;
endmodule

// File: tb/tb_uzorak_deserializer.sv
// Directed bench for uzorak_deserializer: a frame-position model predicts every
// output each cycle, and literal expectations pin key values of the model.
module tb_uzorak_deserializer;
    localparam int N = 60;
    localparam int W = 16;

    logic       clk;
    logic       rst_n;
    logic       frame_err;
    logic [7:0] sample_cnt;

    uzorak_deserializer_if #(.N_FEAT(N), .W(W)) bus ();

    uzorak_deserializer #(.N_FEAT(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .frame_err  (frame_err),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int err_pulses = 0;
    int valid_cycles = 0;

    // Model: position of the next word inside the current frame. Words at
    // position >= N belong to an over-long frame and are thrown away.
    logic [N*W-1:0] m_vec;
    logic           m_full;
    logic           m_err;
    logic [7:0]     m_cnt;
    int             m_pos;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vec  <= '0;
            m_full <= 1'b0;
            m_err  <= 1'b0;
            m_cnt  <= 8'd0;
            m_pos  <= 0;
        end else begin
            m_err <= 1'b0;
            if (m_full) begin
                if (bus.uzorak_ready) begin
                    m_full <= 1'b0;
                    m_cnt  <= m_cnt + 8'd1;
                end
            end else if (bus.in_valid) begin
                if (m_pos < N) m_vec[N*W-1-m_pos*W -: W] <= bus.in_data;
                if (bus.in_last) begin
                    m_pos <= 0;
                    if (m_pos == N-1) m_full <= 1'b1;
                    else if (m_pos < N-1) m_err <= 1'b1;
                end else begin
                    m_pos <= m_pos + 1;
                    if (m_pos == N-1) m_err <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        int n;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        n = 0;
        while (!bus.in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready stuck 0, expected 1 within 1000 cycles");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = W'($urandom);
    endtask

    task automatic good_frame(input int base);
        for (int k = 0; k < N; k++) send(W'(base + k), k == N-1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_uzorak_zero"}, {31'd0, (bus.uzorak != '0)}, 32'd0);
        chk({tag, "_uzorak_valid"}, {31'd0, bus.uzorak_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_sample_cnt"}, {24'd0, sample_cnt}, 32'd0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_values("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic monitor();
        int bad;
        forever begin
            @(negedge clk);
            if (frame_err) err_pulses++;
            if (bus.uzorak_valid) valid_cycles++;
            chk("mdl_in_ready", {31'd0, bus.in_ready}, {31'd0, !m_full});
            chk("mdl_uzorak_valid", {31'd0, bus.uzorak_valid}, {31'd0, m_full});
            chk("mdl_frame_err", {31'd0, frame_err}, {31'd0, m_err});
            chk("mdl_sample_cnt", {24'd0, sample_cnt}, {24'd0, m_cnt});
            bad = 0;
            for (int k = N-1; k >= 0; k--)
                if (bus.uzorak[N*W-1-k*W -: W] !== m_vec[N*W-1-k*W -: W]) bad = k;
            chk($sformatf("mdl_uzorak_word%0d", bad),
                {16'd0, bus.uzorak[N*W-1-bad*W -: W]}, {16'd0, m_vec[N*W-1-bad*W -: W]});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int v0;
        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_last      = 1'b0;
        bus.in_data      = '0;
        bus.uzorak_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("init");
        rst_n = 1'b1;
        fork
            monitor();
        join_none

        // Good frame, downstream always ready
        e0 = err_pulses; v0 = valid_cycles;
        good_frame(1);
        chk("good_top", {16'd0, bus.uzorak[959:944]}, 32'h0001);
        chk("good_bottom", {16'd0, bus.uzorak[15:0]}, 32'h003C);
        chk("good_valid_now", {31'd0, bus.uzorak_valid}, 32'd1);
        @(posedge clk); #1;
        chk("good_valid_len", valid_cycles - v0, 32'd1);
        chk("good_cnt", {24'd0, sample_cnt}, 32'd1);
        chk("good_no_err", err_pulses - e0, 32'd0);
        $display("txn good_frame cnt=%0d", sample_cnt);

        // Backpressure: hold 20 cycles with a word waiting
        bus.uzorak_ready = 1'b0;
        good_frame(16'h0200);
        bus.in_data  = 16'hAAAA;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_hold", {16'd0, bus.uzorak[15:0]}, 32'h023B);
        end
        bus.uzorak_ready = 1'b1;
        for (int k = 0; k < N; k++) send(16'hAAAA + 16'(k), k == N-1);
        chk("bp_new_top", {16'd0, bus.uzorak[959:944]}, 32'hAAAA);
        @(posedge clk); #1;
        chk("bp_cnt", {24'd0, sample_cnt}, 32'd3);
        $display("txn backpressure cnt=%0d", sample_cnt);

        // Short frame then good frame
        do_reset();
        e0 = err_pulses; v0 = valid_cycles;
        for (int k = 0; k < 10; k++) send(16'h0050 + 16'(k), k == 9);
        chk("short_err_pulse", {31'd0, frame_err}, 32'd1);
        @(posedge clk); #1;
        chk("short_err_drop", {31'd0, frame_err}, 32'd0);
        good_frame(16'h0100);
        chk("short_next_top", {16'd0, bus.uzorak[959:944]}, 32'h0100);
        @(posedge clk); #1;
        chk("short_cnt", {24'd0, sample_cnt}, 32'd1);
        chk("short_errs", err_pulses - e0, 32'd1);
        chk("short_valids", valid_cycles - v0, 32'd1);
        $display("txn short_frame errs=%0d", err_pulses - e0);

        // Long frame then good frame
        do_reset();
        e0 = err_pulses; v0 = valid_cycles;
        for (int k = 0; k < 70; k++) begin
            if (k >= N) chk("long_drop_ready", {31'd0, bus.in_ready}, 32'd1);
            send(16'h0700 + 16'(k), k == 69);
            if (k == N-1) chk("long_err_at60", {31'd0, frame_err}, 32'd1);
        end
        chk("long_errs", err_pulses - e0, 32'd1);
        chk("long_no_valid", valid_cycles - v0, 32'd0);
        good_frame(16'h0300);
        chk("long_next_top", {16'd0, bus.uzorak[959:944]}, 32'h0300);
        chk("long_next_bottom", {16'd0, bus.uzorak[15:0]}, 32'h033B);
        @(posedge clk); #1;
        chk("long_cnt", {24'd0, sample_cnt}, 32'd1);
        $display("txn long_frame errs=%0d", err_pulses - e0);

        // Reset mid-fill with gaps, then good frame
        do_reset();
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            send(16'h0900 + 16'(k), 1'b0);
        end
        rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        good_frame(16'h0400);
        chk("rst_next_bottom", {16'd0, bus.uzorak[15:0]}, 32'h043B);
        @(posedge clk); #1;
        chk("rst_next_cnt", {24'd0, sample_cnt}, 32'd1);
        $display("txn reset_gaps cnt=%0d", sample_cnt);

        // Counter wrap after 256 samples
        do_reset();
        for (int f = 0; f < 256; f++) begin
            good_frame(f * 7);
            @(posedge clk); #1;
            if (f == 254) chk("wrap_255", {24'd0, sample_cnt}, 32'd255);
        end
        chk("wrap_zero", {24'd0, sample_cnt}, 32'd0);
        $display("txn wrap cnt=%0d", sample_cnt);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
